// File: rtl/ac_mode_ctrl_if.sv
// Front-panel / actuator bundle for the air-conditioner mode sequencer.
//  key_mode/key_up/key_down : raw active-high keys, asynchronous to clk
//  mode_state               : 00=OFF 01=FAN 10=COOL 11=HEAT
//  fan_speed                : 0..3 (shown as speed 1..4)
//  fan_on/comp_on/heat_on   : actuator enables
//  comp_wait                : COOL requested, compressor held off by restart guard
//  HEX7                     : active-low 7-seg {dp,g..a}
//  LED                      : one-hot mode indicator
// master = panel/board side (drives keys), slave = controller.
interface ac_mode_ctrl_if;
    logic       key_mode;
    logic       key_up;
    logic       key_down;
    logic [1:0] mode_state;
    logic [1:0] fan_speed;
    logic       fan_on;
    logic       comp_on;
    logic       comp_wait;
    logic       heat_on;
    logic [7:0] HEX7;
    logic [3:0] LED;

    modport master (
        output key_mode, key_up, key_down,
        input  mode_state, fan_speed, fan_on, comp_on, comp_wait, heat_on, HEX7, LED
    );
    modport slave (
        input  key_mode, key_up, key_down,
        output mode_state, fan_speed, fan_on, comp_on, comp_wait, heat_on, HEX7, LED
    );
endinterface

// File: rtl/ac_mode_ctrl.sv
// Operating-mode sequencer for the air-conditioner controller.
// Debounces the three panel keys, steps OFF->FAN->COOL->HEAT->OFF on mode presses,
// owns the fan speed (up/down keys plus sleep ramp-down in COOL/HEAT), and gates the
// compressor with a minimum off-time guard.
//  clk : system clock, rising edge
//  rst : asynchronous reset, active-high
//  bus : ac_mode_ctrl_if.slave (keys in; mode, speed, enables, HEX7, LED out)
module ac_mode_ctrl #(
    parameter int DEB_CYCLES   = 20,
    parameter int SLEEP_CYCLES = 1000,
    parameter int COMP_GUARD   = 500
) (
    input  logic         clk,
    input  logic         rst,
    ac_mode_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int IW = $clog2(SLEEP_CYCLES + 1);
    localparam int GW = $clog2(COMP_GUARD + 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_FAN  = 2'b01,
        S_COOL = 2'b10,
        S_HEAT = 2'b11
    } state_t;

    // ---------------- key path: bit 0 = mode, 1 = up, 2 = down ----------------
    logic [2:0]    raw, sync1, sync2, deb, evt;
    logic [DW-1:0] dcnt [3];

    assign raw = {bus.key_down, bus.key_up, bus.key_mode};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            evt   <= '0;
            for (int k = 0; k < 3; k++) dcnt[k] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int k = 0; k < 3; k++) begin
                evt[k] <= 1'b0;
                if (sync2[k] == deb[k]) begin
                    dcnt[k] <= '0;
                end else if (dcnt[k] == DW'(DEB_CYCLES - 1)) begin
                    // DEB_CYCLES-th consecutive differing sample: accept it
                    deb[k]  <= sync2[k];
                    dcnt[k] <= '0;
                    evt[k]  <= sync2[k];
                end else begin
                    dcnt[k] <= dcnt[k] + 1'b1;
                end
            end
        end
    end

    // ---------------- mode / speed / timers ----------------
    state_t        st, st_n;
    logic [1:0]    spd, spd_n;
    logic [IW-1:0] idle, idle_n;
    logic [GW-1:0] guard, guard_n;
    logic          comp_q, comp_on;
    logic [7:0]    hex, hex_n;
    logic [3:0]    led, led_n;

    assign comp_on = (st == S_COOL) && (guard == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= S_OFF;
            spd    <= 2'd0;
            idle   <= '0;
            guard  <= '0;
            comp_q <= 1'b0;
            hex    <= 8'hbf;
            led    <= 4'b0001;
        end else begin
            st     <= st_n;
            spd    <= spd_n;
            idle   <= idle_n;
            guard  <= guard_n;
            comp_q <= comp_on;
            hex    <= hex_n;
            led    <= led_n;
        end
    end

    always_comb begin
        st_n    = st;
        spd_n   = spd;
        idle_n  = idle;
        guard_n = guard;
        hex_n   = 8'hbf;
        led_n   = 4'b0001 << st;

        // mode press wins over any speed press in the same cycle
        if (evt[0]) begin
            st_n = state_t'(st + 2'd1);
            if (st_n == S_OFF) spd_n = 2'd0;
        end else if (st != S_OFF && (evt[1] ^ evt[2])) begin
            if (evt[1] && spd != 2'd3) spd_n = spd + 2'd1;
            if (evt[2] && spd != 2'd0) spd_n = spd - 2'd1;
        end

        // sleep ramp only runs on quiet cycles, so it never collides with a key change
        if (st == S_COOL || st == S_HEAT) begin
            if (|evt) begin
                idle_n = '0;
            end else if (idle == IW'(SLEEP_CYCLES - 1)) begin
                idle_n = '0;
                if (spd != 2'd0) spd_n = spd - 2'd1;
            end else begin
                idle_n = idle + 1'b1;
            end
        end else begin
            idle_n = '0;
        end

        // guard starts on the falling edge of the compressor enable
        if (comp_q && !comp_on)  guard_n = GW'(COMP_GUARD - 1);
        else if (guard != '0)    guard_n = guard - 1'b1;

        if (st != S_OFF) begin
            case (spd)
                2'd0:    hex_n = 8'hf9;
                2'd1:    hex_n = 8'ha4;
                2'd2:    hex_n = 8'hb0;
                default: hex_n = 8'h99;
            endcase
        end
    end

    assign bus.mode_state = st;
    assign bus.fan_speed  = spd;
    assign bus.fan_on     = (st != S_OFF);
    assign bus.comp_on    = comp_on;
    assign bus.comp_wait  = (st == S_COOL) && (guard != '0);
    assign bus.heat_on    = (st == S_HEAT);
    assign bus.HEX7       = hex;
    assign bus.LED        = led;
endmodule

// File: tb/tb_ac_mode_ctrl.sv
module tb_ac_mode_ctrl;
    localparam int DEB = 20;
    localparam int SLP = 1000;
    localparam int GRD = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ac_mode_ctrl_if bus ();

    ac_mode_ctrl #(.DEB_CYCLES(DEB), .SLEEP_CYCLES(SLP), .COMP_GUARD(GRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] seg(input int st, input int spd);
        logic [7:0] tbl [4];
        tbl[0] = 8'hf9; tbl[1] = 8'ha4; tbl[2] = 8'hb0; tbl[3] = 8'h99;
        return (st == 0) ? 8'hbf : tbl[spd];
    endfunction

    // ---------------- behavioural reference ----------------
    int         m_st, m_spd, m_quiet;
    logic [7:0] m_hex;
    logic [3:0] m_led;
    bit         m_comp, m_dropped;
    longint     m_tdrop;
    bit   [2:0] m_evt, m_d1, m_d2, m_deb;
    int         m_run [3];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_st = 0; m_spd = 0; m_quiet = 0;
            m_hex = 8'hbf; m_led = 4'b0001;
            m_comp = 0; m_dropped = 0; m_tdrop = 0;
            m_evt = 0; m_d1 = 0; m_d2 = 0; m_deb = 0;
            for (int k = 0; k < 3; k++) m_run[k] = 0;
        end else begin
            bit [2:0] keys, ev, ne;
            int       pre;
            bit       now;
            cyc++;
            keys  = {bus.key_down, bus.key_up, bus.key_mode};
            ev    = m_evt;
            pre   = m_st;
            // display shows the state/speed held before this edge
            m_hex = seg(m_st, m_spd);
            m_led = 4'(1 << m_st);

            if (ev[0]) begin
                m_st = (m_st + 1) % 4;
                if (m_st == 0) m_spd = 0;
            end else if (pre != 0 && ev[1] != ev[2]) begin
                if (ev[1]) m_spd = (m_spd < 3) ? m_spd + 1 : 3;
                else       m_spd = (m_spd > 0) ? m_spd - 1 : 0;
            end

            if (pre >= 2) begin
                if (ev != 0) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == SLP) begin
                        m_quiet = 0;
                        if (m_spd > 0) m_spd--;
                    end
                end
            end else m_quiet = 0;

            now = (m_st == 2) && (!m_dropped || (cyc - m_tdrop) >= GRD);
            if (m_comp && !now) begin
                m_dropped = 1;
                m_tdrop   = cyc;
            end
            m_comp = now;

            // key reaches the debouncer two edges late; accept after DEB equal samples
            ne = 0;
            for (int k = 0; k < 3; k++) begin
                if (m_d2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_deb[k] = m_d2[k];
                        m_run[k] = 0;
                        ne[k]    = m_d2[k];
                    end
                end else m_run[k] = 0;
            end
            m_d2  = m_d1;
            m_d1  = keys;
            m_evt = ne;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("mode_state", 32'(bus.mode_state), 32'(m_st));
        chk("fan_speed",  32'(bus.fan_speed),  32'(m_spd));
        chk("fan_on",     32'(bus.fan_on),     32'(m_st != 0));
        chk("comp_on",    32'(bus.comp_on),    32'(m_comp));
        chk("comp_wait",  32'(bus.comp_wait),  32'(m_st == 2 && !m_comp));
        chk("heat_on",    32'(bus.heat_on),    32'(m_st == 3));
        chk("heat_comp_excl", 32'(bus.heat_on & bus.comp_on), 32'd0);
        chk("HEX7",       32'(bus.HEX7),       32'(m_hex));
        chk("LED",        32'(bus.LED),        32'(m_led));
    end

    // ---------------- stimulus ----------------
    task automatic setkeys(input bit [2:0] k);
        bus.key_mode = k[0];
        bus.key_up   = k[1];
        bus.key_down = k[2];
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit [2:0] k, input int on, input int off);
        setkeys(k);
        idle(on);
        setkeys(3'b000);
        idle(off);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int     exp_mode [4];
        int     exp_led  [4];
        int     exp_hex  [4];
        longint c0;
        int     n;
        exp_mode[0] = 1; exp_mode[1] = 2; exp_mode[2] = 3; exp_mode[3] = 0;
        exp_led[0]  = 2; exp_led[1]  = 4; exp_led[2]  = 8; exp_led[3]  = 1;
        exp_hex[0]  = 'hf9; exp_hex[1] = 'hf9; exp_hex[2] = 'hf9; exp_hex[3] = 'hbf;

        setkeys(3'b000);
        idle(3);
        chk("rst_mode", 32'(bus.mode_state), 32'd0);
        chk("rst_hex",  32'(bus.HEX7), 32'hbf);
        chk("rst_led",  32'(bus.LED),  32'b0001);
        chk("rst_fan",  32'(bus.fan_on), 32'd0);
        rst = 1'b0;
        idle(2);

        // full mode cycle
        for (int i = 0; i < 4; i++) begin
            press(3'b001, 30, 30);
            chk("cycle_mode", 32'(bus.mode_state), 32'(exp_mode[i]));
            chk("cycle_led",  32'(bus.LED),  32'(exp_led[i]));
            chk("cycle_hex",  32'(bus.HEX7), 32'(exp_hex[i]));
        end

        // bounce, then one clean press with exact latency
        repeat (4) press(3'b001, 5, 5);
        idle(30);
        chk("bounce_none", 32'(bus.mode_state), 32'd0);
        setkeys(3'b001);
        idle(22);
        chk("latency_t22", 32'(bus.mode_state), 32'd0);
        idle(1);
        chk("latency_t23", 32'(bus.mode_state), 32'd1);
        idle(7);
        setkeys(3'b000);
        idle(40);
        chk("single_event", 32'(bus.mode_state), 32'd1);

        // fan speed saturation in FAN
        repeat (5) press(3'b010, 30, 30);
        chk("up_sat",     32'(bus.fan_speed), 32'd3);
        chk("up_sat_hex", 32'(bus.HEX7), 32'h99);
        repeat (5) press(3'b100, 30, 30);
        chk("down_sat",   32'(bus.fan_speed), 32'd0);
        press(3'b010, 30, 30);
        press(3'b110, 30, 30);
        chk("up_down_drop", 32'(bus.fan_speed), 32'd1);

        // sleep ramp in COOL, restarted by a key press
        press(3'b010, 30, 30);
        press(3'b010, 30, 30);
        press(3'b001, 30, 30);
        chk("cool_entry", 32'(bus.mode_state), 32'd2);
        idle(1000);
        chk("ramp_1", 32'(bus.fan_speed), 32'd2);
        idle(1000);
        chk("ramp_2", 32'(bus.fan_speed), 32'd1);
        press(3'b010, 30, 30);
        idle(940);
        chk("ramp_restart", 32'(bus.fan_speed), 32'd2);
        idle(60);
        chk("ramp_3", 32'(bus.fan_speed), 32'd1);
        chk("cool_comp", 32'(bus.comp_on), 32'd1);

        // compressor restart guard
        c0 = cyc;
        repeat (4) press(3'b001, 30, 30);
        chk("guard_mode", 32'(bus.mode_state), 32'd2);
        chk("guard_wait", 32'(bus.comp_wait), 32'd1);
        chk("guard_off",  32'(bus.comp_on), 32'd0);
        n = 0;
        while (!bus.comp_on && n < 1000) begin
            idle(1);
            n++;
        end
        chk("guard_release", 32'(cyc - c0), 32'd523);

        // async reset mid-ramp and mid-guard
        idle(300);
        press(3'b001, 30, 30);
        idle(100);
        #2 rst = 1'b1;
        #1;
        chk("arst_mode",  32'(bus.mode_state), 32'd0);
        chk("arst_speed", 32'(bus.fan_speed), 32'd0);
        chk("arst_hex",   32'(bus.HEX7), 32'hbf);
        chk("arst_led",   32'(bus.LED), 32'b0001);
        chk("arst_heat",  32'(bus.heat_on), 32'd0);
        chk("arst_fan",   32'(bus.fan_on), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        press(3'b001, 30, 30);
        setkeys(3'b001);
        idle(23);
        chk("post_rst_cool", 32'(bus.mode_state), 32'd2);
        chk("post_rst_comp", 32'(bus.comp_on), 32'd1);
        idle(7);
        setkeys(3'b000);
        idle(30);

        // randomized key traffic, including glitches and coincident presses
        repeat (150) begin
            press(3'($urandom_range(1, 7)), $urandom_range(2, 45), $urandom_range(2, 60));
            if ($urandom_range(0, 9) == 0) idle($urandom_range(900, 2200));
        end

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
